// File: rtl/cr_rom_arbiter.sv
// Round-robin arbiter sharing one character-ROM read port between two requesters,
// with glyph burst lock, starvation cap and tagged read-latency tracking.
// Optional grant/conflict statistics counters: define CR_ARB_STATS_EN.
module cr_rom_arbiter #(
  parameter int CR_ADDRSIZE = 9,
  parameter int CR_DATASIZE = 13,
  parameter int ROM_LAT     = 1,
  parameter int MAX_BURST   = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   lock0,
  input  logic [CR_ADDRSIZE-1:0] addr0,
  output logic                   gnt0,
  output logic                   rvalid0,
  input  logic                   req1,
  input  logic                   lock1,
  input  logic [CR_ADDRSIZE-1:0] addr1,
  output logic                   gnt1,
  output logic                   rvalid1,
  output logic [CR_DATASIZE-1:0] rdata,
  output logic [CR_ADDRSIZE-1:0] CR_A,
  input  logic [CR_DATASIZE-1:0] CR_Q,
  output logic [15:0]            stat_gnt0,
  output logic [15:0]            stat_gnt1,
  output logic [15:0]            stat_conf
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                 state_q, state_d;
  logic [5:0]             burst_q, burst_d;
  logic                   last_q, last_d;
  logic                   gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [CR_ADDRSIZE-1:0] cr_a_q, cr_a_d;
  logic [ROM_LAT-1:0]     pv_q, pv_d, pid_q, pid_d;
  logic [ROM_LAT:0]       pv_ext, pid_ext;

  logic win, win_id, rr_id, rr_lock;
  logic own_act, own_id, own_req, own_lock, oth_req, oth_lock, cap;

  always_comb begin
    // Tie goes to whoever was not granted last
    rr_id    = (req0 && req1) ? ~last_q : req1;
    rr_lock  = rr_id ? lock1 : lock0;
    own_act  = (state_q != IDLE);
    own_id   = (state_q == OWN1);
    own_req  = own_id ? req1 : req0;
    own_lock = own_id ? lock1 : lock0;
    oth_req  = own_id ? req0 : req1;
    oth_lock = own_id ? lock0 : lock1;
    cap      = (burst_q >= 6'(MAX_BURST));

    win     = 1'b0;
    win_id  = 1'b0;
    state_d = IDLE;
    burst_d = 6'd0;

    if (own_act && own_req && own_lock) begin
      if (oth_req && cap) begin
        win    = 1'b1;
        win_id = ~own_id;
        if (oth_lock) begin
          state_d = own_id ? OWN0 : OWN1;
          burst_d = 6'd1;
        end
      end else begin
        win     = 1'b1;
        win_id  = own_id;
        state_d = state_q;
        burst_d = cap ? burst_q : burst_q + 6'd1;
      end
    end else if (req0 || req1) begin
      win    = 1'b1;
      win_id = rr_id;
      if (rr_lock) begin
        state_d = rr_id ? OWN1 : OWN0;
        burst_d = 6'd1;
      end
    end

    gnt0_d = win & ~win_id;
    gnt1_d = win & win_id;
    cr_a_d = win ? (win_id ? addr1 : addr0) : cr_a_q;
    last_d = win ? win_id : last_q;

    // Tag pipe: stage 0 follows the registered grant, oldest stage drives rvalid
    pv_ext  = {pv_q, gnt0_q | gnt1_q};
    pid_ext = {pid_q, gnt1_q};
    pv_d    = pv_ext[ROM_LAT-1:0];
    pid_d   = pid_ext[ROM_LAT-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= 6'd0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      cr_a_q  <= '0;
      pv_q    <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      cr_a_q  <= cr_a_d;
      pv_q    <= pv_d;
      pid_q   <= pid_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign CR_A    = cr_a_q;
  assign rvalid0 = pv_q[ROM_LAT-1] & ~pid_q[ROM_LAT-1];
  assign rvalid1 = pv_q[ROM_LAT-1] &  pid_q[ROM_LAT-1];
  assign rdata   = CR_Q;

`ifdef CR_ARB_STATS_EN
  logic [15:0] sg0_q, sg0_d, sg1_q, sg1_d, sconf_q, sconf_d;

  always_comb begin
    sg0_d   = (gnt0_d && sg0_q != 16'hFFFF) ? sg0_q + 16'd1 : sg0_q;
    sg1_d   = (gnt1_d && sg1_q != 16'hFFFF) ? sg1_q + 16'd1 : sg1_q;
    sconf_d = (req0 && req1 && sconf_q != 16'hFFFF) ? sconf_q + 16'd1 : sconf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sg0_q   <= 16'd0;
      sg1_q   <= 16'd0;
      sconf_q <= 16'd0;
    end else begin
      sg0_q   <= sg0_d;
      sg1_q   <= sg1_d;
      sconf_q <= sconf_d;
    end
  end

  assign stat_gnt0 = sg0_q;
  assign stat_gnt1 = sg1_q;
  assign stat_conf = sconf_q;
`else
  assign stat_gnt0 = 16'd0;
  assign stat_gnt1 = 16'd0;
  assign stat_conf = 16'd0;
`endif

endmodule

// File: tb/tb_cr_rom_arbiter.sv
// Bench for cr_rom_arbiter: table-driven grant checks plus a scoreboard that
// matches each expected read return against rvalid/rdata and its arrival cycle.
module tb_cr_rom_arbiter;
  localparam int AW  = 9;
  localparam int DW  = 13;
  localparam int LAT = 1;
  localparam int MB  = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata, cr_q;
  logic [AW-1:0] cr_a;
  logic [15:0]   stat_gnt0, stat_gnt1, stat_conf;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  cr_rom_arbiter #(.CR_ADDRSIZE(AW), .CR_DATASIZE(DW), .ROM_LAT(LAT), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .CR_A(cr_a), .CR_Q(cr_q),
    .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conf(stat_conf)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {a[3:0], a} ^ 13'h0A5A;
  endfunction

  // ROM model with one cycle of read latency
  always @(posedge clk) begin
    cr_q <= rom(cr_a);
    cyc  <= cyc + 1;
  end

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic          rst, r0, l0;
    logic [AW-1:0] a0;
    logic          r1, l1;
    logic [AW-1:0] a1;
    logic          eg0, eg1;
    logic [AW-1:0] ecra;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, r0, l0, input logic [AW-1:0] a0,
                              input logic r1, l1, input logic [AW-1:0] a1,
                              input logic eg0, eg1, input logic [AW-1:0] ecra);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.l0 = l0; v.a0 = a0;
    v.r1 = r1; v.l1 = l1; v.a1 = a1;
    v.eg0 = eg0; v.eg1 = eg1; v.ecra = ecra;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    reset = v.rst; req0 = v.r0; lock0 = v.l0; addr0 = v.a0;
    req1 = v.r1; lock1 = v.l1; addr1 = v.a1;
    @(posedge clk);
    #1;
    check("gnt0", gnt0, v.eg0);
    check("gnt1", gnt1, v.eg1);
    check("CR_A", cr_a, v.ecra);
    if (v.rst) begin
      sb.delete();
      check("rvalid0_rst", rvalid0, 1'b0);
      check("rvalid1_rst", rvalid1, 1'b0);
    end
    if (v.eg0) sb.push_back('{1'b0, rom(v.a0), cyc + LAT});
    if (v.eg1) sb.push_back('{1'b1, rom(v.a1), cyc + LAT});
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b, required none (cycle %0d)",
                 rvalid0, rvalid1, cyc);
      end else begin
        e = sb.pop_front();
        check("rvalid_id", {30'd0, rvalid1, rvalid0}, e.id ? 32'd2 : 32'd1);
        check("rdata", rdata, e.data);
        check("rvalid_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    int exp_conf, exp_g;
`ifdef CR_ARB_STATS_EN
    exp_conf = 6; exp_g = 3;
`else
    exp_conf = 0; exp_g = 0;
`endif
    // single request, then a six-cycle tie
    tbl.push_back(mk(1, 0,0,  0, 0,0,  0, 0,0,  0));
    tbl.push_back(mk(1, 0,0,  0, 0,0,  0, 0,0,  0));
    tbl.push_back(mk(0, 1,0, 48, 0,0,  0, 1,0, 48));
    tbl.push_back(mk(0, 0,0, 48, 0,0,  0, 0,0, 48));
    tbl.push_back(mk(0, 0,0, 48, 0,0,  0, 0,0, 48));
    tbl.push_back(mk(1, 0,0,  0, 0,0,  0, 0,0,  0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 1,0, 10, 1,0, 20, ~i[0], i[0], i[0] ? 9'd20 : 9'd10));
    tbl.push_back(mk(0, 0,0, 10, 0,0, 20, 0,0, 20));

    foreach (tbl[i]) step(tbl[i]);
    check("stat_conf_tie", stat_conf, exp_conf);
    check("stat_gnt0_tie", stat_gnt0, exp_g);
    check("stat_gnt1_tie", stat_gnt1, exp_g);

    // lock release: OWN1 for five grants, then release with req0 pending
    tbl.delete();
    tbl.push_back(mk(1, 0,0,  0, 0,0,   0, 0,0,   0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0,0,  0, 1,1, 100, 0,1, 100));
    tbl.push_back(mk(0, 1,0, 33, 1,0, 101, 1,0,  33));
    tbl.push_back(mk(0, 1,0, 34, 1,0, 101, 0,1, 101));
    tbl.push_back(mk(0, 0,0, 34, 0,0, 101, 0,0, 101));
    // lock without req is ignored
    tbl.push_back(mk(0, 0,1, 34, 1,0,   7, 0,1,   7));
    tbl.push_back(mk(0, 1,0,  8, 1,0,   7, 1,0,   8));
    tbl.push_back(mk(0, 0,0,  8, 0,0,   7, 0,0,   8));
    foreach (tbl[i]) step(tbl[i]);

    // burst cap: 24 locked grants to 0, one to 1, then 0 again
    step(mk(1, 0,0, 0, 0,0, 0, 0,0, 0));
    for (int i = 0; i < MB + 2; i++) begin
      logic [AW-1:0] a;
      a = 9'(50 + ((i < MB) ? i : MB));
      step(mk(0, 1,1, a, 1,0, 200, (i != MB), (i == MB), (i == MB) ? 9'd200 : a));
    end
    step(mk(0, 0,0, 74, 0,0, 200, 0,0, 74));

    // reset right after a grant kills the in-flight read
    step(mk(0, 0,0,  0, 1,0, 240, 0,1, 240));
    step(mk(1, 0,0,  0, 0,0,   0, 0,0,   0));
    check("stat_gnt0_rst", stat_gnt0, 0);
    check("stat_gnt1_rst", stat_gnt1, 0);
    check("stat_conf_rst", stat_conf, 0);
    step(mk(0, 1,0,  5, 1,0,   6, 1,0,   5));
    step(mk(0, 1,0,  5, 1,0,   6, 0,1,   6));
    step(mk(0, 0,0,  5, 0,0,   6, 0,0,   6));
    check("stat_conf_post", stat_conf, (exp_conf != 0) ? 2 : 0);
    check("stat_gnt0_post", stat_gnt0, (exp_g != 0) ? 1 : 0);

    for (int i = 0; i < LAT + 2; i++) step(mk(0, 0,0, 5, 0,0, 6, 0,0, 6));
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
